// File: rtl/img2col_pkg.sv
// Shared types and sizing helpers for the img2col sliding-window scheduler.
package img2col_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    SHIFT,
    DONE
  } sched_state_t;

  // Output rows/columns produced by a k x k window at stride 1 over a row x row map.
  function automatic int out_dim(input int row, input int k);
    return row - k + 1;
  endfunction

  // Index width for a counter spanning 0..n-1 (never zero bits wide).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img2col_sched_ring_ptr.sv
// Mod-N wrapping pointer with synchronous clear and increment enable.
// Wrap is a compare against N-1, so no divider is needed.
module ring_ptr #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Pointer update: reset/clear to 0, otherwise step and wrap at N-1.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == W'(N - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/img2col_sched.sv
// img2col sliding-window scheduler: fills a K-row ring buffer from the input
// stream, emits every window column to the PU vector, then replaces the
// oldest row and repeats until all (ROW-K+1)^2 columns are consumed.
// Optional macro SCHED_PERF_CNT_EN adds stall_cnt / starve_cnt outputs.
module img2col_sched
  import img2col_pkg::*;
#(
  parameter int ROW = 28,
  parameter int K   = 5,
  parameter int CW  = 64,
  localparam int SW = idx_w(K),
  localparam int XW = idx_w(ROW)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [SW-1:0] wr_slot,
  output logic [XW-1:0] wr_col,
  output logic          col_valid,
  input  logic          col_ready,
  output logic [SW-1:0] rd_base,
  output logic [XW-1:0] rd_col,
  output logic [CW-1:0] col_num,
  output logic          busy,
`ifdef SCHED_PERF_CNT_EN
  output logic [31:0]   stall_cnt,
  output logic [31:0]   starve_cnt,
`endif
  output logic          map_finish
);

  localparam int OUT = out_dim(ROW, K);
  localparam logic [XW-1:0] LAST_COL = XW'(ROW - 1);
  localparam logic [XW-1:0] LAST_OUT = XW'(OUT - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(K - 1);

  if (ROW < K) begin : g_bad_cfg
    $error("img2col_sched: ROW must be >= K");
  end

  sched_state_t  r_state;
  logic          r_in_ready;
  logic          r_col_valid;
  logic          r_busy;
  logic          r_map_finish;
  logic [XW-1:0] r_wr_col;
  logic [XW-1:0] r_rd_col;
  logic [XW-1:0] r_out_row;
  logic [CW-1:0] r_col_num;

  logic [SW-1:0] w_load_row;
  logic [SW-1:0] w_rd_base;
  logic          w_wr_en;
  logic          w_row_done;
  logic          w_hs;
  logic          w_start_acc;
  logic          w_load_inc;
  logic          w_base_inc;

  assign w_wr_en     = in_valid && r_in_ready;
  assign w_row_done  = w_wr_en && (r_wr_col == LAST_COL);
  assign w_hs        = r_col_valid && col_ready;
  assign w_start_acc = (r_state == IDLE) && start;
  assign w_load_inc  = (r_state == LOAD) && w_row_done;
  assign w_base_inc  = (r_state == SHIFT) && w_row_done;

  ring_ptr #(.N(K), .W(SW)) u_load_row (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_clr  (w_start_acc),
    .i_inc  (w_load_inc),
    .o_ptr  (w_load_row)
  );

  ring_ptr #(.N(K), .W(SW)) u_rd_base (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_clr  (w_start_acc),
    .i_inc  (w_base_inc),
    .o_ptr  (w_rd_base)
  );

  // Scheduler FSM with registered handshake/status outputs and column counters.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b0;
      r_col_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_map_finish <= 1'b0;
      r_wr_col     <= '0;
      r_rd_col     <= '0;
      r_out_row    <= '0;
      r_col_num    <= '0;
    end else begin
      r_map_finish <= 1'b0;
      if (w_wr_en) begin
        r_wr_col <= (r_wr_col == LAST_COL) ? '0 : r_wr_col + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_wr_col   <= '0;
            r_rd_col   <= '0;
            r_out_row  <= '0;
            r_col_num  <= '0;
          end
        end
        LOAD: begin
          if (w_load_inc && (w_load_row == LAST_SLOT)) begin
            r_state     <= EMIT;
            r_in_ready  <= 1'b0;
            r_col_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (w_hs) begin
            r_col_num <= r_col_num + 1'b1;
            if (r_rd_col < LAST_OUT) begin
              r_rd_col <= r_rd_col + 1'b1;
            end else begin
              r_rd_col    <= '0;
              r_col_valid <= 1'b0;
              if (r_out_row == LAST_OUT) begin
                r_state      <= DONE;
                r_map_finish <= 1'b1;
              end else begin
                r_state    <= SHIFT;
                r_in_ready <= 1'b1;
              end
            end
          end
        end
        SHIFT: begin
          if (w_base_inc) begin
            r_out_row   <= r_out_row + 1'b1;
            r_state     <= EMIT;
            r_in_ready  <= 1'b0;
            r_col_valid <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_starve_cnt;

  // Saturating stall (PU back-pressure) and starve (input empty) cycle counters.
  always_ff @(posedge clk) begin
    if (!nrst || w_start_acc) begin
      r_stall_cnt  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (r_col_valid && !col_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (r_in_ready && !in_valid && (r_starve_cnt != '1)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign starve_cnt = r_starve_cnt;
`endif

  assign in_ready   = r_in_ready;
  assign wr_en      = w_wr_en;
  assign wr_slot    = (r_state == SHIFT) ? w_rd_base : w_load_row;
  assign wr_col     = r_wr_col;
  assign col_valid  = r_col_valid;
  assign rd_base    = w_rd_base;
  assign rd_col     = r_rd_col;
  assign col_num    = r_col_num;
  assign busy       = r_busy;
  assign map_finish = r_map_finish;

endmodule

// File: doc/img2col_sched.md
Name: img2col_sched

Overview:
- Controller that sequences the img2col sliding-window datapath over one square feature map of ROW x ROW pixels with a K x K kernel at stride 1.
- Accepts pixel words from the AXI-side stream and steers them into a K-slot row ring buffer.
- Schedules every output column (window position) to the processing-unit vector through a valid/ready handshake.
- Sits between the AXI input stream and the PU vector; owns all row, column, round and slot counters.

Parameters:
- ROW, 28, feature-map width and height in pixels
- K, 5, kernel size; ROW >= K is enforced by an elaboration assertion
- CW, 64, width of col_num

Ports:
- clk  input  1  clock
- nrst  input  1  synchronous active-low reset
- start  input  1  begin one feature map; sampled only in IDLE
- in_valid  input  1  pixel word available on AXI stream
- in_ready  output  1  scheduler accepts a pixel word this cycle
- wr_en  output  1  write in_data to ring buffer; equals in_valid && in_ready
- wr_slot  output  $clog2(K)  ring-buffer row slot being written
- wr_col  output  $clog2(ROW)  column within slot being written
- col_valid  output  1  window column available to PU vector
- col_ready  input  1  PU vector consumes the column
- rd_base  output  $clog2(K)  ring slot holding the top row of the current window
- rd_col  output  $clog2(ROW)  leftmost column of the current window
- col_num  output  CW  linear output-column index, 0..(ROW-K+1)^2-1
- busy  output  1  high in every state except IDLE
- map_finish  output  1  one-cycle pulse when the final column has been consumed

Behaviour:
- Reset (nrst=0 at a clk edge): state IDLE; all counters 0; in_ready, wr_en, col_valid, busy and map_finish are 0; rd_base, rd_col, wr_slot, wr_col and col_num are 0. Reset mid-operation aborts immediately with no partial map_finish.
- Derived constant: OUT = ROW-K+1 output rows and columns; total columns OUT*OUT.
- IDLE:
  - start=1 moves to LOAD next cycle; otherwise stay.
  - in_ready=0.
  - start is ignored in every other state.
- LOAD (fill K rows):
  - in_ready=1.
  - Each accepted word writes slot=load_row, col=wr_col.
  - wr_col wraps ROW-1 -> 0 and increments load_row.
  - After the K*ROW-th accept, go to EMIT with rd_base=0, out_row=0, rd_col=0.
- EMIT:
  - col_valid=1 and in_ready=0; rd_base, rd_col and col_num are held stable until col_ready.
  - On col_valid && col_ready: col_num increments.
  - If rd_col < OUT-1, rd_col increments.
  - Otherwise rd_col returns to 0, and:
    - if out_row == OUT-1, go to DONE;
    - else go to SHIFT.
- SHIFT (replace the oldest row):
  - in_ready=1; writes target wr_slot=rd_base, columns 0..ROW-1.
  - After the ROW-th accept: rd_base = (rd_base+1) mod K, out_row++, return to EMIT.
- DONE: map_finish=1 for exactly one cycle, busy still 1; next state IDLE. start asserted in DONE is ignored.
- Latency:
  - The first col_valid is asserted in the cycle after the K*ROW-th accepted word.
  - A column handshake in one cycle allows the next column's col_valid in the same following cycle, giving 1 column/cycle throughput under continuous col_ready.
- in_valid with in_ready=0 is ignored; no word is lost because the source holds it.
- The ring-slot modulo is computed without a divider (compare to K-1, wrap to 0).
- col_num wraps naturally at 2^CW; this is unreachable for legal parameters.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt (32 bits), counting cycles with col_valid && !col_ready.
  - Also adds output starve_cnt (32 bits), counting cycles with in_ready && !in_valid.
  - Both counters clear on reset and on start accepted in IDLE, and saturate at all-ones.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package img2col_pkg holds:
  - enum sched_state_t {IDLE, LOAD, EMIT, SHIFT, DONE};
  - localparam functions for OUT and the slot/column widths.
- One natural sub-module, ring_ptr: a mod-K wrapping counter with increment enable. It is instanced for load_row/rd_base.
- The column counters stay inline.

Test Plan:
- ROW=6, K=3, in_valid and col_ready held 1, pulse start:
  - exactly 18 accepts precede the first col_valid;
  - 16 columns are emitted;
  - 36 words are accepted in total;
  - map_finish pulses once, one cycle after the 16th handshake.
- Same config, check the rd_base sequence across output rows: 0, 1, 2, 0. Check that SHIFT wr_slot matches the pre-increment rd_base each time.
- Random col_ready (50%): rd_col, rd_base and col_num are held stable while col_valid && !col_ready; col_num reaches 15 with no skips or duplicates.
- Reset asserted mid-SHIFT: the next cycle is IDLE with all outputs 0 and no map_finish. A new start then completes a full map normally.
- start pulsed during EMIT and DONE is ignored. start held high through DONE re-enters LOAD on the first cycle back in IDLE.
- With SCHED_PERF_CNT_EN and ROW=6, K=3: col_ready held low 4 cycles on column 5 gives stall_cnt=4. in_valid dropped 3 cycles during LOAD gives starve_cnt=3.
